// File: rtl/pifo_io_port_arb_if.sv
// Client request/response and per-slot PIFO bundle; flattened per-port/per-slot fields.
// slave = arbiter side, master = clients plus sub-tree array side.
interface pifo_io_port_arb_if #(
    parameter int PTW      = 16,
    parameter int MTW      = 0,
    parameter int N_PORT   = 2,
    parameter int LEVEL    = 4,
    parameter int TREE_NUM = 4
);
    localparam int W   = MTW + PTW;
    localparam int TNB = (TREE_NUM > 1) ? $clog2(TREE_NUM) : 1;
    localparam int PB  = (N_PORT > 1) ? $clog2(N_PORT) : 1;

    logic [N_PORT-1:0]       i_req_valid;
    logic [N_PORT-1:0]       i_req_pop;
    logic [N_PORT*TNB-1:0]   i_req_tree_id;
    logic [N_PORT*W-1:0]     i_req_data;
    logic [N_PORT-1:0]       o_req_ready;
    logic [LEVEL-1:0]        o_push;
    logic [LEVEL-1:0]        o_pop;
    logic [LEVEL*TNB-1:0]    o_tree_id;
    logic [LEVEL*W-1:0]      o_push_data;
    logic [LEVEL-1:0]        i_task_fifo_full;
    logic [LEVEL*W-1:0]      i_pop_data;
    logic [LEVEL-1:0]        i_pop_data_valid;
    logic [LEVEL-1:0]        o_rsp_valid;
    logic [LEVEL*PB-1:0]     o_rsp_port;
    logic [LEVEL*W-1:0]      o_rsp_data;
    logic                    o_err;

    modport slave (
        input  i_req_valid, i_req_pop, i_req_tree_id, i_req_data,
        input  i_task_fifo_full, i_pop_data, i_pop_data_valid,
        output o_req_ready, o_push, o_pop, o_tree_id, o_push_data,
        output o_rsp_valid, o_rsp_port, o_rsp_data, o_err
    );

    modport master (
        output i_req_valid, i_req_pop, i_req_tree_id, i_req_data,
        output i_task_fifo_full, i_pop_data, i_pop_data_valid,
        input  o_req_ready, o_push, o_pop, o_tree_id, o_push_data,
        input  o_rsp_valid, o_rsp_port, o_rsp_data, o_err
    );
endinterface

// File: rtl/pifo_io_port_arb.sv
// N-client front end for the PIFO sub-tree array: per-slot round-robin, 1-cycle registered strobes/responses.
// Clients back-pressured by slot task-FIFO-full and a full per-slot pop tag FIFO; responses are never stalled.
module pifo_io_port_arb #(
    parameter int PTW       = 16,
    parameter int MTW       = 0,
    parameter int N_PORT    = 2,
    parameter int LEVEL     = 4,
    parameter int TREE_NUM  = 4,
    parameter int TAG_DEPTH = 8
) (
    input logic                 i_clk,
    input logic                 i_arst,
    pifo_io_port_arb_if.slave   bus
);
    localparam int W   = MTW + PTW;
    localparam int TNB = (TREE_NUM > 1) ? $clog2(TREE_NUM) : 1;
    localparam int PB  = (N_PORT > 1) ? $clog2(N_PORT) : 1;
    localparam int LB  = $clog2(LEVEL);
    localparam int TAB = $clog2(TAG_DEPTH);
    localparam int CB  = TAB + 1;

    logic [TNB-1:0]     req_tid  [N_PORT];
    logic [W-1:0]       req_dat  [N_PORT];
    logic [LB-1:0]      req_slot [N_PORT];

    logic [LEVEL-1:0]   win_vld, win_pop, hs, tag_wr, tag_rd;
    logic [PB-1:0]      win_port [LEVEL];
    logic [TNB-1:0]     win_tid  [LEVEL];
    logic [W-1:0]       win_dat  [LEVEL];
    logic [N_PORT-1:0]  req_rdy;
    int                 scan_tgt;

    logic [PB-1:0]      rr_ptr_q     [LEVEL];
    logic [PB-1:0]      tag_mem_q    [LEVEL][TAG_DEPTH];
    logic [TAB-1:0]     tag_wr_ptr_q [LEVEL];
    logic [TAB-1:0]     tag_rd_ptr_q [LEVEL];
    logic [CB-1:0]      tag_cnt_q    [LEVEL];

    logic [LEVEL-1:0]       push_q, pop_q, rsp_valid_q;
    logic [LEVEL*TNB-1:0]   tree_id_q;
    logic [LEVEL*W-1:0]     push_data_q, rsp_data_q;
    logic [LEVEL*PB-1:0]    rsp_port_q;
    logic                   err_q;

    always_comb begin
        for (int p = 0; p < N_PORT; p++) begin
            req_tid[p]  = bus.i_req_tree_id[p*TNB +: TNB];
            req_dat[p]  = bus.i_req_data[p*W +: W];
            req_slot[p] = LB'(req_tid[p]);
        end
    end

    // Winner = first requesting port at or after rr_ptr, scanning upward with wrap.
    always_comb begin
        win_vld  = '0;
        win_pop  = '0;
        hs       = '0;
        tag_wr   = '0;
        tag_rd   = '0;
        req_rdy  = '0;
        scan_tgt = 0;
        for (int r = 0; r < LEVEL; r++) begin
            win_port[r] = '0;
            win_tid[r]  = '0;
            win_dat[r]  = '0;
            for (int i = 0; i < N_PORT; i++) begin
                scan_tgt = (int'(rr_ptr_q[r]) + i) % N_PORT;
                for (int p = 0; p < N_PORT; p++) begin
                    if (!win_vld[r] && p == scan_tgt && bus.i_req_valid[p] &&
                        req_slot[p] == LB'(r)) begin
                        win_vld[r]  = 1'b1;
                        win_port[r] = PB'(p);
                        win_pop[r]  = bus.i_req_pop[p];
                        win_tid[r]  = req_tid[p];
                        win_dat[r]  = req_dat[p];
                    end
                end
            end
            hs[r] = win_vld[r] && !bus.i_task_fifo_full[r] && !i_arst &&
                    (!win_pop[r] || tag_cnt_q[r] < CB'(TAG_DEPTH));
            tag_wr[r] = hs[r] && win_pop[r];
            tag_rd[r] = bus.i_pop_data_valid[r] && (tag_cnt_q[r] != '0);
            for (int p = 0; p < N_PORT; p++) begin
                if (hs[r] && win_port[r] == PB'(p)) req_rdy[p] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            push_q      <= '0;
            pop_q       <= '0;
            tree_id_q   <= '0;
            push_data_q <= '0;
            rsp_valid_q <= '0;
            rsp_port_q  <= '0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
            for (int r = 0; r < LEVEL; r++) begin
                rr_ptr_q[r]     <= '0;
                tag_wr_ptr_q[r] <= '0;
                tag_rd_ptr_q[r] <= '0;
                tag_cnt_q[r]    <= '0;
                for (int t = 0; t < TAG_DEPTH; t++) tag_mem_q[r][t] <= '0;
            end
        end else begin
            for (int r = 0; r < LEVEL; r++) begin
                if (hs[r]) rr_ptr_q[r] <= PB'((int'(win_port[r]) + 1) % N_PORT);
                push_q[r]                <= hs[r] && !win_pop[r];
                pop_q[r]                 <= hs[r] && win_pop[r];
                tree_id_q[r*TNB +: TNB]  <= hs[r] ? win_tid[r] : '0;
                push_data_q[r*W +: W]    <= (hs[r] && !win_pop[r]) ? win_dat[r] : '0;

                if (tag_wr[r]) begin
                    tag_mem_q[r][tag_wr_ptr_q[r]] <= win_port[r];
                    tag_wr_ptr_q[r]               <= tag_wr_ptr_q[r] + 1'b1;
                end
                if (tag_rd[r]) tag_rd_ptr_q[r] <= tag_rd_ptr_q[r] + 1'b1;
                if (tag_wr[r] && !tag_rd[r])      tag_cnt_q[r] <= tag_cnt_q[r] + 1'b1;
                else if (!tag_wr[r] && tag_rd[r]) tag_cnt_q[r] <= tag_cnt_q[r] - 1'b1;

                rsp_valid_q[r]        <= tag_rd[r];
                rsp_port_q[r*PB +: PB] <= tag_rd[r] ? tag_mem_q[r][tag_rd_ptr_q[r]] : '0;
                rsp_data_q[r*W +: W]  <= tag_rd[r] ? bus.i_pop_data[r*W +: W] : '0;
                // Data with no outstanding tag is dropped; flag it permanently.
                if (bus.i_pop_data_valid[r] && tag_cnt_q[r] == '0) err_q <= 1'b1;
            end
        end
    end

    assign bus.o_req_ready = req_rdy;
    assign bus.o_push      = push_q;
    assign bus.o_pop       = pop_q;
    assign bus.o_tree_id   = tree_id_q;
    assign bus.o_push_data = push_data_q;
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_port  = rsp_port_q;
    assign bus.o_rsp_data  = rsp_data_q;
    assign bus.o_err       = err_q;
endmodule

// File: tb/tb_pifo_io_port_arb.sv
// Directed bench for pifo_io_port_arb: routing, round-robin, back-pressure, tag FIFO, error and reset.
module tb_pifo_io_port_arb;
    localparam int PTW = 16, MTW = 0, N_PORT = 2, LEVEL = 4, TREE_NUM = 8, TAG_DEPTH = 8;
    localparam int W = 16, TNB = 3, PB = 1;

    logic clk = 1'b0;
    logic arst;
    int checks = 0;
    int errors = 0;

    pifo_io_port_arb_if #(.PTW(PTW), .MTW(MTW), .N_PORT(N_PORT), .LEVEL(LEVEL),
                          .TREE_NUM(TREE_NUM)) bus ();

    pifo_io_port_arb #(.PTW(PTW), .MTW(MTW), .N_PORT(N_PORT), .LEVEL(LEVEL),
                       .TREE_NUM(TREE_NUM), .TAG_DEPTH(TAG_DEPTH)) dut (
        .i_clk (clk),
        .i_arst(arst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        bus.i_req_valid      = '0;
        bus.i_req_pop        = '0;
        bus.i_req_tree_id    = '0;
        bus.i_req_data       = '0;
        bus.i_task_fifo_full = '0;
        bus.i_pop_data       = '0;
        bus.i_pop_data_valid = '0;
    endtask

    task automatic req(input int p, input logic pop, input int tid, input logic [15:0] dat);
        bus.i_req_valid[p]              = 1'b1;
        bus.i_req_pop[p]                = pop;
        bus.i_req_tree_id[p*TNB +: TNB] = TNB'(tid);
        bus.i_req_data[p*W +: W]        = dat;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        arst = 1'b1;
        clr();
        #2;
        chk("rst_push", 64'(bus.o_push), 64'h0);
        chk("rst_rsp_valid", 64'(bus.o_rsp_valid), 64'h0);
        chk("rst_err", 64'(bus.o_err), 64'h0);
        req(0, 1'b0, 6, 16'h1234);
        #1 chk("rst_ready", 64'(bus.o_req_ready), 64'h0);
        clr();
        tick();
        tick();
        arst = 1'b0;

        // Single push to tree 6 -> slot 2
        req(0, 1'b0, 6, 16'h1234);
        #1 chk("push_ready", 64'(bus.o_req_ready), 64'h1);
        tick();
        clr();
        chk("push_strobe", 64'(bus.o_push), 64'h4);
        chk("push_pop0", 64'(bus.o_pop), 64'h0);
        chk("push_tid2", 64'(bus.o_tree_id[2*TNB +: TNB]), 64'd6);
        chk("push_dat2", 64'(bus.o_push_data[2*W +: W]), 64'h1234);
        tick();
        chk("push_idle", 64'(bus.o_push), 64'h0);
        chk("push_idle_tid", 64'(bus.o_tree_id), 64'h0);

        // Contention on slot 1: alternating grants
        req(0, 1'b1, 1, 16'h0);
        req(1, 1'b1, 1, 16'h0);
        for (int k = 0; k < 4; k++) begin
            #1 chk("rr_ready", 64'(bus.o_req_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
            tick();
            chk("rr_pop", 64'(bus.o_pop), 64'h2);
            chk("rr_tid", 64'(bus.o_tree_id[1*TNB +: TNB]), 64'd1);
            chk("rr_popdata", 64'(bus.o_push_data[1*W +: W]), 64'h0);
        end
        clr();
        for (int k = 0; k < 4; k++) begin
            bus.i_pop_data_valid[1]  = 1'b1;
            bus.i_pop_data[1*W +: W] = 16'hA000 + 16'(k);
            tick();
            chk("rr_rsp_valid", 64'(bus.o_rsp_valid), 64'h2);
            chk("rr_rsp_port", 64'(bus.o_rsp_port[1*PB +: PB]), 64'(k % 2));
            chk("rr_rsp_data", 64'(bus.o_rsp_data[1*W +: W]), 64'hA000 + 64'(k));
        end
        clr();
        tick();
        chk("rr_rsp_done", 64'(bus.o_rsp_valid), 64'h0);
        chk("rr_no_err", 64'(bus.o_err), 64'h0);

        // Parallel slots 0 and 3
        req(0, 1'b0, 0, 16'h1111);
        req(1, 1'b0, 3, 16'h3333);
        #1 chk("par_ready", 64'(bus.o_req_ready), 64'h3);
        tick();
        clr();
        chk("par_push", 64'(bus.o_push), 64'h9);
        chk("par_dat0", 64'(bus.o_push_data[0*W +: W]), 64'h1111);
        chk("par_dat3", 64'(bus.o_push_data[3*W +: W]), 64'h3333);
        chk("par_tid3", 64'(bus.o_tree_id[3*TNB +: TNB]), 64'd3);

        // Back-pressure on slot 2
        bus.i_task_fifo_full[2] = 1'b1;
        req(0, 1'b0, 2, 16'h2222);
        #1 chk("bp_ready", 64'(bus.o_req_ready), 64'h0);
        tick();
        chk("bp_no_push", 64'(bus.o_push), 64'h0);
        bus.i_task_fifo_full[2] = 1'b0;
        #1 chk("bp_release_ready", 64'(bus.o_req_ready), 64'h1);
        tick();
        clr();
        chk("bp_push", 64'(bus.o_push), 64'h4);
        chk("bp_dat", 64'(bus.o_push_data[2*W +: W]), 64'h2222);

        // Tag FIFO full on slot 0: first pop from port 1 via tree 4, then port 0
        for (int k = 0; k < 8; k++) begin
            clr();
            if (k == 0) req(1, 1'b1, 4, 16'h0);
            else        req(0, 1'b1, 0, 16'h0);
            #1 chk("tf_ready", 64'(bus.o_req_ready), (k == 0) ? 64'h2 : 64'h1);
            tick();
            chk("tf_pop", 64'(bus.o_pop), 64'h1);
        end
        clr();
        req(0, 1'b1, 0, 16'h0);
        bus.i_pop_data_valid[0]  = 1'b1;
        bus.i_pop_data[0*W +: W] = 16'hBEEF;
        #1 chk("tf_full_ready", 64'(bus.o_req_ready), 64'h0);
        tick();
        bus.i_pop_data_valid[0] = 1'b0;
        chk("tf_full_no_pop", 64'(bus.o_pop), 64'h0);
        chk("tf_rsp_valid", 64'(bus.o_rsp_valid), 64'h1);
        chk("tf_rsp_port", 64'(bus.o_rsp_port[0*PB +: PB]), 64'h1);
        chk("tf_rsp_data", 64'(bus.o_rsp_data[0*W +: W]), 64'hBEEF);
        #1 chk("tf_ninth_ready", 64'(bus.o_req_ready), 64'h1);
        tick();
        clr();
        chk("tf_ninth_pop", 64'(bus.o_pop), 64'h1);

        // Pop data on slot 3 with no outstanding tag
        bus.i_pop_data_valid[3]  = 1'b1;
        bus.i_pop_data[3*W +: W] = 16'h5A5A;
        tick();
        clr();
        chk("err_no_rsp", 64'(bus.o_rsp_valid), 64'h0);
        chk("err_set", 64'(bus.o_err), 64'h1);
        tick();
        chk("err_sticky", 64'(bus.o_err), 64'h1);

        // Reset mid-operation with 3 tags pending on slot 1
        req(0, 1'b1, 1, 16'h0);
        for (int k = 0; k < 3; k++) begin
            #1 chk("rst_pend_ready", 64'(bus.o_req_ready), 64'h1);
            tick();
        end
        chk("rst_pend_pop", 64'(bus.o_pop), 64'h2);
        arst = 1'b1;
        #1;
        chk("arst_pop", 64'(bus.o_pop), 64'h0);
        chk("arst_tid", 64'(bus.o_tree_id), 64'h0);
        chk("arst_err", 64'(bus.o_err), 64'h0);
        chk("arst_ready", 64'(bus.o_req_ready), 64'h0);
        clr();
        tick();
        arst = 1'b0;
        tick();
        bus.i_pop_data_valid[1]  = 1'b1;
        bus.i_pop_data[1*W +: W] = 16'h7777;
        tick();
        clr();
        chk("post_rst_no_rsp", 64'(bus.o_rsp_valid), 64'h0);
        chk("post_rst_err", 64'(bus.o_err), 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
